// File: rtl/fp32_pkg.sv
// Shared FP32 field constants, encodings and divider FSM states.
package fp32_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned QBITS  = 26;
    localparam int unsigned EXPS_W = 10;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIV,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp32_mant_div_core.sv
// Iterative restoring mantissa divider: one quotient bit per clock after start.
module fp32_mant_div_core
    import fp32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAN_W:0]   dividend,
    input  logic [MAN_W:0]   divisor,
    output logic [QBITS-1:0] q,
    output logic             rem_nonzero,
    output logic             done
);

    localparam int unsigned REM_W = MAN_W + 2;
    localparam int unsigned CNT_W = $clog2(QBITS);

    logic [REM_W-1:0] rem;
    logic [MAN_W:0]   div_r;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             ge_c;
    logic [REM_W-1:0] rem_sub_c;
    logic [REM_W-1:0] rem_next_c;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        ge_c       = rem >= REM_W'(div_r);
        rem_sub_c  = ge_c ? (rem - REM_W'(div_r)) : rem;
        rem_next_c = {rem_sub_c[REM_W-2:0], 1'b0};
    end

    // Iteration registers; done is high during the cycle of the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            div_r       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            q           <= '0;
            rem_nonzero <= 1'b0;
            done        <= 1'b0;
        end else if (start) begin
            rem         <= REM_W'(dividend);
            div_r       <= divisor;
            cnt         <= CNT_W'(QBITS - 1);
            busy        <= 1'b1;
            q           <= '0;
            rem_nonzero <= 1'b0;
            done        <= 1'b0;
        end else if (busy) begin
            rem         <= rem_next_c;
            q           <= {q[QBITS-2:0], ge_c};
            rem_nonzero <= |rem_next_c;
            cnt         <= cnt - CNT_W'(1);
            busy        <= cnt != '0;
            done        <= cnt == CNT_W'(1);
        end else begin
            done        <= 1'b0;
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Multi-cycle FP32 divider (Out = A / B) with valid/ready handshakes.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out,
    output logic        div_by_zero
);

    state_t state, state_n;
    logic [31:0] a_r, a_n, b_r, b_n, out_n;
    logic        sign_r, sign_n, dbz_n, ov_n, ir_n;
    logic signed [EXPS_W-1:0] exp_r, exp_n;

    fp32_t fa, fb;
    assign fa = a_r;
    assign fb = b_r;

    logic        start_c;
    logic [QBITS-1:0] q;
    logic        rem_nz, core_done;

    logic        sign_c, special_c, spec_dbz_c;
    logic [31:0] spec_out_c, norm_out_c;
    logic signed [EXPS_W-1:0] exp_calc_c, exp_adj_c, exp_fin_c;
    logic [MAN_W-1:0] mant_c;
    logic [MAN_W:0]   mant_rnd_c;
    logic        guard_c, sticky_c, inc_c;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    fp32_mant_div_core u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_c),
        .dividend    ({1'b1, fa.man}),
        .divisor     ({1'b1, fb.man}),
        .q           (q),
        .rem_nonzero (rem_nz),
        .done        (core_done)
    );

    // Operand classification, special-case results and exponent difference.
    always_comb begin
        a_zero     = fa.exp == '0;
        b_zero     = fb.exp == '0;
        a_inf      = (fa.exp == '1) && (fa.man == '0);
        b_inf      = (fb.exp == '1) && (fb.man == '0);
        a_nan      = (fa.exp == '1) && (fa.man != '0);
        b_nan      = (fb.exp == '1) && (fb.man != '0);
        sign_c     = fa.sign ^ fb.sign;
        special_c  = 1'b1;
        spec_dbz_c = 1'b0;
        spec_out_c = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_out_c = QNAN;
        end else if (a_inf) begin
            spec_out_c = {sign_c, POS_INF[30:0]};
        end else if (b_inf || a_zero) begin
            spec_out_c = {sign_c, 31'h0};
        end else if (b_zero) begin
            spec_out_c = {sign_c, POS_INF[30:0]};
            spec_dbz_c = 1'b1;
        end else begin
            special_c  = 1'b0;
        end
        exp_calc_c = $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp})
                   + $signed(EXPS_W'(BIAS));
    end

    // Normalise the quotient, round to nearest even, clamp the exponent range.
    always_comb begin
        if (q[QBITS-1]) begin
            mant_c    = q[QBITS-2:2];
            guard_c   = q[1];
            sticky_c  = q[0] | rem_nz;
            exp_adj_c = exp_r;
        end else begin
            mant_c    = q[QBITS-3:1];
            guard_c   = q[0];
            sticky_c  = rem_nz;
            exp_adj_c = exp_r - EXPS_W'(1);
        end
        inc_c      = guard_c & (sticky_c | mant_c[0]);
        mant_rnd_c = {1'b0, mant_c} + (MAN_W+1)'(inc_c);
        exp_fin_c  = exp_adj_c + (mant_rnd_c[MAN_W] ? EXPS_W'(1) : EXPS_W'(0));
        if (exp_fin_c >= $signed(EXPS_W'(255))) begin
            norm_out_c = {sign_r, POS_INF[30:0]};
        end else if (exp_fin_c <= $signed(EXPS_W'(0))) begin
            norm_out_c = {sign_r, 31'h0};
        end else begin
            norm_out_c = {sign_r, exp_fin_c[EXP_W-1:0], mant_rnd_c[MAN_W-1:0]};
        end
    end

    // Next-state and handshake control.
    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        sign_n  = sign_r;
        exp_n   = exp_r;
        out_n   = Out;
        dbz_n   = div_by_zero;
        ov_n    = out_valid;
        ir_n    = in_ready;
        start_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_n     = A;
                    b_n     = B;
                    ir_n    = 1'b0;
                    state_n = UNPACK;
                end
            end
            UNPACK: begin
                sign_n = sign_c;
                if (special_c) begin
                    out_n   = spec_out_c;
                    dbz_n   = spec_dbz_c;
                    ov_n    = 1'b1;
                    state_n = DONE;
                end else begin
                    exp_n   = exp_calc_c;
                    start_c = 1'b1;
                    state_n = DIV;
                end
            end
            DIV: begin
                if (core_done) begin
                    state_n = NORM;
                end
            end
            NORM: begin
                out_n   = norm_out_c;
                dbz_n   = 1'b0;
                ov_n    = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_n    = 1'b0;
                    ir_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                ir_n    = 1'b1;
                ov_n    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            Out         <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            state       <= state_n;
            a_r         <= a_n;
            b_r         <= b_n;
            sign_r      <= sign_n;
            exp_r       <= exp_n;
            Out         <= out_n;
            div_by_zero <= dbz_n;
            out_valid   <= ov_n;
            in_ready    <= ir_n;
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Directed testbench for fp32_divider.
module tb_fp32_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Out;
    logic        div_by_zero;

    int n_checks;
    int n_errors;

    fp32_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Out         (Out),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One divide: accept, wait for result, optional backpressure stall, handshake.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input logic exp_dbz,
                         input int exp_lat, input int hold);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 32'hDEAD_BEEF;
        B        = 32'h3F80_0000;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, Out, exp_out);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        held = Out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            A        = 32'h4120_0000;
            B        = 32'h4000_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_out"}, Out, held);
            check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        #22;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", Out, 32'h0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("div_21p875_6p25", 32'h41AF_0000, 32'h40C8_0000, 32'h4060_0000, 1'b0, 28, 0);
        do_op("one_third",       32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 28, 0);
        do_op("one_one",         32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 28, 0);
        do_op("one_by_zero",     32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1, 0);
        do_op("zero_by_zero",    32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1, 0);
        do_op("neg_by_inf",      32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0, 1, 0);
        do_op("nan_in",          32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1, 0);
        do_op("inf_by_inf",      32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1, 0);
        do_op("ninf_by_two",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1, 0);
        do_op("zero_by_five",    32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0, 1, 0);
        do_op("overflow",        32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 1'b0, 28, 0);
        do_op("underflow",       32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 28, 0);
        do_op("backpressure",    32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 28, 5);
        do_op("after_stall",     32'h4120_0000, 32'h4080_0000, 32'h4020_0000, 1'b0, 28, 0);

        // Abort a divide mid-iteration with reset.
        @(negedge clk);
        A        = 32'h3F80_0000;
        B        = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out", Out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 28, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
